run_supervisor: RTL
===================

# run_supervisor

Synthesizable run controller that wraps one or more password-search cores. On START it sequences a clean core reset, then enables the cores and counts run cycles against a cycle budget. It stops on the first FOUND from any channel, on timeout or on ABORT, and freezes the result (hit flag, winning channel, cycle count) for the UART reporting logic. It sits between the top-level System glue and the search-core array.

## Interface
Parameters:
- N_CH, 1: number of search-core channels (1..16)
- CNT_W, 32: cycle-counter width
- BUDGET, 200000000: run-cycle budget; must be ≥ 1 and < 2^CNT_W
- RST_HOLD, 4: cycles CORE_RST_N is held low before RUN (≥ 1)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  run request; sampled in IDLE or DONE only
- ABORT  in  1  cancel the run; effective in HOLD or RUN
- FOUND_IN  in  N_CH  per-channel found flags from the cores; level-sensitive
- CORE_RST_N  out  1  active-low reset to the cores
- CORE_EN  out  1  core enable, high only in RUN
- BUSY  out  1  high in HOLD or RUN
- DONE  out  1  high in DONE state
- HIT  out  1  run ended on FOUND
- TIMEOUT  out  1  run ended on budget exhaustion
- HIT_CH  out  max(1,$clog2(N_CH))  lowest-index channel asserting FOUND at the hit cycle
- CYCLES  out  CNT_W  RUN cycles elapsed; frozen when the run ends

## Operation
- FSM states: IDLE, HOLD, RUN, DONE.
- IDLE -> HOLD on START=1. On the same edge, clear HIT, TIMEOUT, HIT_CH and CYCLES, and load hold_cnt with RST_HOLD-1.
- HOLD:
  - CORE_RST_N=0 and CORE_EN=0.
  - hold_cnt decrements each cycle; at 0, go to RUN.
  - The hold lasts exactly RST_HOLD cycles.
- RUN:
  - CORE_RST_N=1 and CORE_EN=1.
  - CYCLES increments by 1 on each RUN cycle that is not terminating.
  - Termination priority per cycle, highest first: ABORT, then FOUND, then timeout.
  - FOUND: |FOUND_IN=1 -> DONE with HIT=1 and HIT_CH = lowest set index. CYCLES holds the current value and is not incremented.
  - Timeout: CYCLES == BUDGET-1 with no FOUND -> DONE with TIMEOUT=1 and CYCLES=BUDGET.
- ABORT in HOLD or RUN -> IDLE. HIT and TIMEOUT stay 0; CYCLES keeps its last value; DONE is not entered.
- DONE:
  - Holds all results and keeps CORE_RST_N=1, CORE_EN=0.
  - START -> HOLD with results cleared, as from IDLE.
  - ABORT is ignored.
- Ignored inputs:
  - START in HOLD or RUN.
  - FOUND_IN outside RUN.
  - ABORT in IDLE or DONE.
- Reset values: state=IDLE, CORE_RST_N=0, CORE_EN=0, BUSY=0, DONE=0, HIT=0, TIMEOUT=0, HIT_CH=0, CYCLES=0.
- Leaving reset into IDLE, CORE_RST_N goes to 1 on the first clock edge. Cores are therefore held in reset for as long as RESET is asserted.
- RESET asserted mid-run: all outputs return to their reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- START high at edge k: CORE_RST_N=0 from k through k+RST_HOLD-1. CORE_EN=1 from edge k+RST_HOLD.
- FOUND_IN seen at RUN edge m: DONE, HIT and HIT_CH are valid after edge m, i.e. 1-cycle latency. CYCLES equals the number of earlier RUN cycles.
- CORE_EN drops on the same edge that DONE rises.

## Configuration
- SUPERVISOR_TIMEOUT_EN:
  - Defined: budget enforced as described above.
  - Undefined: BUDGET is ignored and TIMEOUT is tied to 0. CYCLES saturates at 2^CNT_W-1 and stays there, and the run ends only on FOUND or ABORT.

## Structure
- Shared package `supervisor_pkg` holds:
  - the state enum (IDLE/HOLD/RUN/DONE)
  - the HIT_CH width function
  - the default BUDGET and RST_HOLD constants
- Sub-module `lowest_one_enc` (parameter N_CH): combinational priority encoder producing the lowest set index plus an any-set flag. This is the only sub-module.

## Test plan
- N_CH=1, BUDGET=10, RST_HOLD=4; START pulse, FOUND_IN never set:
  - CORE_RST_N low for 4 cycles, then CORE_EN high for 10 cycles.
  - Result: DONE=1, TIMEOUT=1, HIT=0, CYCLES=10.
- N_CH=4, BUDGET=1000; FOUND_IN=4'b1010 on the 7th RUN cycle:
  - Next cycle: DONE=1, HIT=1, HIT_CH=1, CYCLES=6, CORE_EN=0.
- BUDGET=10; FOUND_IN set on the same cycle CYCLES==9:
  - HIT=1, TIMEOUT=0, CYCLES=9 (FOUND wins).
- ABORT during HOLD, then START during RUN, then ABORT during RUN:
  - Each ABORT returns to IDLE with DONE=0 and HIT=0.
  - The START issued during RUN has no effect.
- RESET driven low mid-RUN:
  - All outputs take their reset values asynchronously.
  - After release, START runs a full HOLD/RUN sequence normally.
- SUPERVISOR_TIMEOUT_EN undefined, CNT_W=4; no FOUND:
  - CYCLES saturates at 15 and the run stays in RUN.
  - A later FOUND_IN gives HIT=1 with CYCLES=15.

Source files
------------

// File: rtl/supervisor_pkg.sv
// Shared types and defaults for the run supervisor and its encoder.
// Pure declarations: no logic, no latency, no flow control.
package supervisor_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam longint unsigned DEF_BUDGET   = 64'd200000000;
   localparam int              DEF_RST_HOLD = 4;

   // A single channel still needs a 1-bit index port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lowest_one_enc.sv
// Lowest-set-bit priority encoder with any-set flag.
// Purely combinational, zero latency, no flow control.
module lowest_one_enc
   import supervisor_pkg::*;
#(
   parameter int N_CH = 1
) (
   input  logic [N_CH-1:0]       hit_vec,
   output logic                  any_set,
   output logic [ch_w(N_CH)-1:0] low_idx
);

   localparam int IDX_W = ch_w(N_CH);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      any_set = |hit_vec;
      low_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (hit_vec[i]) low_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/run_supervisor.sv
// Search run controller: core reset hold, timed run, first-FOUND capture; registered outputs, 1-cycle latency, no backpressure.
// SUPERVISOR_TIMEOUT_EN: defined enforces BUDGET; undefined ties TIMEOUT low and CYCLES saturates.
module run_supervisor
   import supervisor_pkg::*;
#(
   parameter int              N_CH     = 1,
   parameter int              CNT_W    = 32,
   parameter longint unsigned BUDGET   = DEF_BUDGET,
   parameter int              RST_HOLD = DEF_RST_HOLD
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic [N_CH-1:0]       FOUND_IN,
   output logic                  CORE_RST_N,
   output logic                  CORE_EN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  HIT,
   output logic                  TIMEOUT,
   output logic [ch_w(N_CH)-1:0] HIT_CH,
   output logic [CNT_W-1:0]      CYCLES
);

   localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BUDGET - 64'd1);
   localparam logic [CNT_W-1:0]  CNT_BUDG  = CNT_W'(BUDGET);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

`ifdef SUPERVISOR_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   state_t                  state;
   logic [HOLD_W-1:0]       hold_cnt;
   logic                    found_any;
   logic [ch_w(N_CH)-1:0]   found_idx;
   logic                    budget_end;

   lowest_one_enc #(
      .N_CH (N_CH)
   ) u_enc (
      .hit_vec (FOUND_IN),
      .any_set (found_any),
      .low_idx (found_idx)
   );

   assign budget_end = TIMEOUT_EN && (CYCLES == CNT_LAST);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         CORE_RST_N <= 1'b0;
         CORE_EN    <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         HIT        <= 1'b0;
         TIMEOUT    <= 1'b0;
         HIT_CH     <= '0;
         CYCLES     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // Cores leave reset on the first edge after RESET releases.
               CORE_RST_N <= 1'b1;
               if (START) begin
                  state      <= S_HOLD;
                  hold_cnt   <= HOLD_INIT;
                  CORE_RST_N <= 1'b0;
                  CORE_EN    <= 1'b0;
                  BUSY       <= 1'b1;
                  DONE       <= 1'b0;
                  HIT        <= 1'b0;
                  TIMEOUT    <= 1'b0;
                  HIT_CH     <= '0;
                  CYCLES     <= '0;
               end
            end
            S_HOLD: begin
               if (ABORT) begin
                  state      <= S_IDLE;
                  CORE_RST_N <= 1'b1;
                  BUSY       <= 1'b0;
               end else if (hold_cnt == '0) begin
                  state      <= S_RUN;
                  CORE_RST_N <= 1'b1;
                  CORE_EN    <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            S_RUN: begin
               // ABORT beats FOUND beats timeout on the same cycle.
               if (ABORT) begin
                  state   <= S_IDLE;
                  CORE_EN <= 1'b0;
                  BUSY    <= 1'b0;
               end else if (found_any) begin
                  state   <= S_DONE;
                  CORE_EN <= 1'b0;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  HIT     <= 1'b1;
                  HIT_CH  <= found_idx;
               end else if (budget_end) begin
                  state   <= S_DONE;
                  CORE_EN <= 1'b0;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  TIMEOUT <= 1'b1;
                  CYCLES  <= CNT_BUDG;
               end else if (CYCLES != CNT_MAX) begin
                  CYCLES <= CYCLES + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
